// File: rtl/multicycle_control.sv
// Multicycle datapath controller: Moore FSM with registered strobes, decoded from the next state.
// Only IRWrite/PCWrite in FETCH are gated combinationally by mem_ready.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic [1:0] OpALU,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        Fetch  = 4'd0,
        Decode = 4'd1,
        MemAdr = 4'd2,
        MemRd  = 4'd3,
        MemWb  = 4'd4,
        MemWr  = 4'd5,
        Exec   = 4'd6,
        AluWb  = 4'd7,
        Branch = 4'd8,
        AddiEx = 4'd9,
        AddiWb = 4'd10,
        Jump   = 4'd11
    } stateT;

    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    stateT      stateQ, stateD;
    logic [5:0] opcodeQ;
    logic       activeQ;
    logic       illegalD, illegalQ;

    logic [1:0] opAluD, opAluQ, aluSrcBD, aluSrcBQ, pcSourceD, pcSourceQ;
    logic       jumpWriteD, jumpWriteQ, pcWriteCondD, pcWriteCondQ, iorDD, iorDQ;
    logic       memReadD, memReadQ, memWriteD, memWriteQ, memtoRegD, memtoRegQ;
    logic       regDstD, regDstQ, regWriteD, regWriteQ, aluSrcAD, aluSrcAQ;
    logic       fetchD, fetchQ;

    always_comb begin : nextStateLogic
        stateD   = stateQ;
        illegalD = 1'b0;
        if (!activeQ) begin
            // First edge after reset release only arms the controller in FETCH.
            stateD = Fetch;
        end else begin
            case (stateQ)
                Fetch:  if (mem_ready) stateD = Decode;
                Decode: begin
                    case (opcode)
                        OpRType:     stateD = Exec;
                        OpLw, OpSw:  stateD = MemAdr;
                        OpBeq:       stateD = Branch;
                        OpAddi:      stateD = AddiEx;
                        OpJ:         stateD = Jump;
                        default: begin
                            stateD   = Fetch;
                            illegalD = 1'b1;
                        end
                    endcase
                end
                MemAdr: stateD = (opcodeQ == OpLw) ? MemRd : MemWr;
                MemRd:  if (mem_ready) stateD = MemWb;
                MemWr:  if (mem_ready) stateD = Fetch;
                Exec:   stateD = AluWb;
                AddiEx: stateD = AddiWb;
                MemWb, AluWb, AddiWb, Branch, Jump: stateD = Fetch;
                default: stateD = Fetch;
            endcase
        end
    end

    always_comb begin : outputDecode
        opAluD       = 2'b00;
        aluSrcBD     = 2'b00;
        pcSourceD    = 2'b00;
        jumpWriteD   = 1'b0;
        pcWriteCondD = 1'b0;
        iorDD        = 1'b0;
        memReadD     = 1'b0;
        memWriteD    = 1'b0;
        memtoRegD    = 1'b0;
        regDstD      = 1'b0;
        regWriteD    = 1'b0;
        aluSrcAD     = 1'b0;
        fetchD       = 1'b0;
        case (stateD)
            Fetch: begin
                memReadD = 1'b1;
                aluSrcBD = 2'b01;
                fetchD   = 1'b1;
            end
            Decode: aluSrcBD = 2'b11;
            MemAdr, AddiEx: begin
                aluSrcAD = 1'b1;
                aluSrcBD = 2'b10;
            end
            MemRd: begin
                memReadD = 1'b1;
                iorDD    = 1'b1;
            end
            MemWb: begin
                regWriteD = 1'b1;
                memtoRegD = 1'b1;
            end
            MemWr: begin
                memWriteD = 1'b1;
                iorDD     = 1'b1;
            end
            Exec: begin
                aluSrcAD = 1'b1;
                opAluD   = 2'b10;
            end
            AluWb: begin
                regWriteD = 1'b1;
                regDstD   = 1'b1;
            end
            Branch: begin
                aluSrcAD     = 1'b1;
                opAluD       = 2'b01;
                pcWriteCondD = 1'b1;
                pcSourceD    = 2'b01;
            end
            AddiWb: regWriteD = 1'b1;
            Jump: begin
                jumpWriteD = 1'b1;
                pcSourceD  = 2'b10;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ       <= Fetch;
            activeQ      <= 1'b0;
            opcodeQ      <= 6'b000000;
            illegalQ     <= 1'b0;
            opAluQ       <= 2'b00;
            aluSrcBQ     <= 2'b00;
            pcSourceQ    <= 2'b00;
            jumpWriteQ   <= 1'b0;
            pcWriteCondQ <= 1'b0;
            iorDQ        <= 1'b0;
            memReadQ     <= 1'b0;
            memWriteQ    <= 1'b0;
            memtoRegQ    <= 1'b0;
            regDstQ      <= 1'b0;
            regWriteQ    <= 1'b0;
            aluSrcAQ     <= 1'b0;
            fetchQ       <= 1'b0;
        end else begin
            stateQ       <= stateD;
            activeQ      <= 1'b1;
            if (activeQ && stateQ == Decode) opcodeQ <= opcode;
            illegalQ     <= illegalD;
            opAluQ       <= opAluD;
            aluSrcBQ     <= aluSrcBD;
            pcSourceQ    <= pcSourceD;
            jumpWriteQ   <= jumpWriteD;
            pcWriteCondQ <= pcWriteCondD;
            iorDQ        <= iorDD;
            memReadQ     <= memReadD;
            memWriteQ    <= memWriteD;
            memtoRegQ    <= memtoRegD;
            regDstQ      <= regDstD;
            regWriteQ    <= regWriteD;
            aluSrcAQ     <= aluSrcAD;
            fetchQ       <= fetchD;
        end
    end

    assign state       = stateQ;
    assign illegal     = illegalQ;
    assign OpALU       = opAluQ;
    assign ALUSrcB     = aluSrcBQ;
    assign PCSource    = pcSourceQ;
    assign PCWriteCond = pcWriteCondQ;
    assign IorD        = iorDQ;
    assign MemRead     = memReadQ;
    assign MemWrite    = memWriteQ;
    assign MemtoReg    = memtoRegQ;
    assign RegDst      = regDstQ;
    assign RegWrite    = regWriteQ;
    assign ALUSrcA     = aluSrcAQ;
    assign IRWrite     = fetchQ & mem_ready;
    assign PCWrite     = jumpWriteQ | (fetchQ & mem_ready);

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized instruction stream for multicycle_control; expected per-cycle outputs
// come from instruction state paths and the per-state output table, checked by a monitor.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'b0;
    logic       mem_ready = 1'b0;
    logic [1:0] OpALU, ALUSrcB, PCSource;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal;
    logic [3:0] state;

    multicycle_control dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .OpALU      (OpALU),
        .PCWrite    (PCWrite),
        .PCWriteCond(PCWriteCond),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .MemtoReg   (MemtoReg),
        .RegDst     (RegDst),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCSource   (PCSource),
        .state      (state),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] OpLw   = 6'b100011;
    localparam logic [5:0] OpSw   = 6'b101011;
    localparam logic [5:0] OpR    = 6'b000000;
    localparam logic [5:0] OpBeq  = 6'b000100;
    localparam logic [5:0] OpAddi = 6'b001000;
    localparam logic [5:0] OpJ    = 6'b000010;

    int          compared = 0;
    int          mismatched = 0;
    logic [20:0] expQ[$];
    logic        illPending = 1'b0;
    logic [20:0] dutVec;

    assign dutVec = {state, OpALU, ALUSrcB, PCSource, PCWrite, PCWriteCond, IorD, MemRead,
                     MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, illegal};

    // Output vector a state should present, straight from the per-state output table.
    function automatic logic [20:0] expOut(input int st, input logic mr, input logic ill);
        logic [3:0] s;
        logic [1:0] opAlu, srcB, pcSrc;
        logic       pcW, pcWC, iorD, mRd, mWr, irW, m2r, rDst, rW, srcA;
        s = 4'(st);
        opAlu = 2'b00; srcB = 2'b00; pcSrc = 2'b00;
        pcW = 0; pcWC = 0; iorD = 0; mRd = 0; mWr = 0; irW = 0; m2r = 0; rDst = 0; rW = 0;
        srcA = 0;
        case (st)
            0:  begin mRd = 1; srcB = 2'b01; pcW = mr; irW = mr; end
            1:  srcB = 2'b11;
            2:  begin srcA = 1; srcB = 2'b10; end
            3:  begin mRd = 1; iorD = 1; end
            4:  begin rW = 1; m2r = 1; end
            5:  begin mWr = 1; iorD = 1; end
            6:  begin srcA = 1; opAlu = 2'b10; end
            7:  begin rW = 1; rDst = 1; end
            8:  begin srcA = 1; opAlu = 2'b01; pcWC = 1; pcSrc = 2'b01; end
            9:  begin srcA = 1; srcB = 2'b10; end
            10: rW = 1;
            11: begin pcW = 1; pcSrc = 2'b10; end
            default: ;
        endcase
        return {s, opAlu, srcB, pcSrc, pcW, pcWC, iorD, mRd, mWr, irW, m2r, rDst, rW, srcA,
                ill && (st == 0)};
    endfunction

    function automatic bit isLegal(input logic [5:0] op);
        return op == OpLw || op == OpSw || op == OpR || op == OpBeq || op == OpAddi || op == OpJ;
    endfunction

    task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    initial begin : monitor
        logic [20:0] e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                check("cycle", dutVec, e);
            end
        end
    end

    task automatic doCycle(input int st, input logic mr, input logic [5:0] op);
        @(posedge clk);
        #1;
        mem_ready = mr;
        opcode    = op;
        expQ.push_back(expOut(st, mr, illPending));
        if (st == 0) illPending = 1'b0;
    endtask

    // One instruction: walk its state path, stalling memory states with mem_ready=0.
    task automatic runInstr(input logic [5:0] op, input int fetchStall, input int stallMax);
        int path[$];
        bit legal;
        int n;
        legal = 1;
        case (op)
            OpLw:   path = '{0, 1, 2, 3, 4};
            OpSw:   path = '{0, 1, 2, 5};
            OpR:    path = '{0, 1, 6, 7};
            OpAddi: path = '{0, 1, 9, 10};
            OpBeq:  path = '{0, 1, 8};
            OpJ:    path = '{0, 1, 11};
            default: begin path = '{0, 1}; legal = 0; end
        endcase
        foreach (path[i]) begin
            if (path[i] == 0 || path[i] == 3 || path[i] == 5) begin
                n = (path[i] == 0 && fetchStall >= 0) ? fetchStall
                                                      : int'($urandom_range(stallMax, 0));
                for (int k = 0; k < n; k++) doCycle(path[i], 1'b0, 6'($urandom));
                doCycle(path[i], 1'b1, 6'($urandom));
            end else begin
                doCycle(path[i], 1'($urandom_range(1, 0)),
                        (path[i] == 1) ? op : 6'($urandom));
            end
        end
        if (!legal) illPending = 1'b1;
    endtask

    initial begin : stimulus
        logic [5:0] ops[6];
        logic [5:0] op;
        int guard;
        ops[0] = OpLw; ops[1] = OpSw; ops[2] = OpR; ops[3] = OpAddi; ops[4] = OpBeq; ops[5] = OpJ;

        reset = 1'b1;
        mem_ready = 1'b1;
        opcode = 6'b111111;
        repeat (2) @(posedge clk);
        #2 check("reset_hold", dutVec, 21'd0);
        @(negedge clk);
        check("reset_hold_negedge", dutVec, 21'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        runInstr(OpLw, 0, 0);
        runInstr(OpR, 0, 0);
        runInstr(OpSw, 0, 0);
        runInstr(OpR, 3, 0);
        runInstr(6'b111111, 0, 0);
        runInstr(OpBeq, 0, 0);
        runInstr(OpJ, 0, 0);
        runInstr(OpAddi, 0, 0);

        repeat (200) begin
            int idx;
            idx = int'($urandom_range(6, 0));
            if (idx == 6) begin
                do op = 6'($urandom); while (isLegal(op));
            end else begin
                op = ops[idx];
            end
            runInstr(op, -1, 2);
        end

        // sw interrupted by reset while waiting in MEMWR
        doCycle(0, 1'b1, 6'($urandom));
        doCycle(1, 1'b1, OpSw);
        doCycle(2, 1'b1, 6'($urandom));
        doCycle(5, 1'b0, 6'($urandom));
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check("async_reset_memwr", dutVec, 21'd0);
        @(posedge clk);
        #2 check("reset_edge_held", dutVec, 21'd0);
        reset = 1'b0;
        illPending = 1'b0;
        runInstr(OpLw, 0, 0);
        runInstr(OpJ, 0, 0);

        guard = 0;
        while (expQ.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (expQ.size() > 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d entries left, expected 0", expQ.size());
        end
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port opcode, input, [0:5]: instruction opcode field, sampled in DECODE.
REQ-004 SHALL have port mem_ready, input, 1 bit: memory access completes this cycle.
REQ-005 SHALL have port OpALU, output, [0:1]: ALU-control class; 00 add, 01 sub, 10 use funct.
REQ-006 SHALL have outputs PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, each 1 bit: datapath strobes and selects.
REQ-007 SHALL have outputs ALUSrcB [0:1] and PCSource [0:1].
- ALUSrcB: 00 B, 01 constant 4, 10 sign-extended immediate, 11 immediate<<2.
- PCSource: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-008 SHALL have outputs state [0:3] (current state code) and illegal (1 bit, one-cycle pulse on an unknown opcode).

Function
REQ-009 SHALL implement a Moore FSM with these state codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-010 SHALL decode opcodes in DECODE and take the next state from the opcode:
- 000000 -> EXEC
- 100011 or 101011 -> MEMADR
- 000100 -> BRANCH
- 001000 -> ADDIEX
- 000010 -> JUMP
- any other opcode -> FETCH, with illegal=1 for exactly the following cycle.
REQ-011 SHALL route MEMADR to MEMRD for opcode 100011 and to MEMWR otherwise, using the opcode value held from DECODE.
REQ-012 SHALL follow these transitions unconditionally: MEMWB, ALUWB, ADDIWB, BRANCH and JUMP -> FETCH; EXEC -> ALUWB; ADDIEX -> ADDIWB.
REQ-013 SHALL hold FETCH, MEMRD and MEMWR while mem_ready=0; with mem_ready=1 they advance to DECODE, MEMWB and FETCH respectively.
REQ-014 SHALL drive, per state (all unlisted outputs 0):
- FETCH: MemRead=1, ALUSrcB=01, OpALU=00, PCSource=00; IRWrite=PCWrite=mem_ready.
- DECODE: ALUSrcB=11, OpALU=00.
- MEMADR: ALUSrcA=1, ALUSrcB=10, OpALU=00.
- MEMRD: MemRead=1, IorD=1.
- MEMWB: RegWrite=1, MemtoReg=1.
- MEMWR: MemWrite=1, IorD=1.
- EXEC: ALUSrcA=1, OpALU=10.
- ALUWB: RegWrite=1, RegDst=1.
- BRANCH: ALUSrcA=1, OpALU=01, PCWriteCond=1, PCSource=01.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, OpALU=00.
- ADDIWB: RegWrite=1.
- JUMP: PCWrite=1, PCSource=10.
REQ-015 SHALL keep all outputs except the mem_ready-gated strobes free of any dependence on the inputs.
REQ-016 SHALL assert at most one of MemRead and MemWrite in any cycle, and SHALL never assert RegWrite in a state that accesses memory.
REQ-017 SHALL treat any unused state code (12-15) as FETCH on the next edge, asserting no strobes while in it.
REQ-018 SHALL produce the following cycle counts with mem_ready held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Reset
REQ-019 SHALL, while reset=1, force state=FETCH and drive every output, including illegal, to 0, independent of clk.
REQ-020 SHALL, on reset assertion mid-instruction, abandon the instruction immediately with no further write strobes, and resume at FETCH on the first rising edge after deassertion.

Verification
REQ-021 SHALL cover lw (opcode 100011) with mem_ready=1 -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-022 SHALL cover R-type (opcode 000000) -> states 0,1,6,7,0; OpALU=10 in state 6; RegDst=1 and RegWrite=1 in state 7.
REQ-023 SHALL cover FETCH with mem_ready=0 for 3 cycles -> state stays 0, IRWrite=PCWrite=0; then mem_ready=1 -> IRWrite=PCWrite=1 for one cycle, next state 1.
REQ-024 SHALL cover opcode 111111 in DECODE -> next state 0 with illegal=1 for exactly one cycle, and no RegWrite or MemWrite asserted.
REQ-025 SHALL cover sw with reset asserted asynchronously during state 5 -> state=0 and MemWrite=0 immediately; after release, the next instruction starts at FETCH.
REQ-026 SHALL cover beq (000100) then j (000010) -> state 8 with OpALU=01 and PCWriteCond=1; state 11 with PCWrite=1 and PCSource=10.
